// File: rtl/calc_entry_ctrl.sv
// calc_entry_ctrl: keypad operand/operator entry, RAM write-out, and signed binary-to-BCD result display.
module calc_entry_ctrl #(
  parameter int DIGITS     = 2,
  parameter int RES_DIGITS = 4,
  parameter int DATA_W     = 32,
  parameter int OP1_ADDR   = 20000,
  parameter int OPC_ADDR   = 20200,
  parameter int OP2_ADDR   = 20400
)(
  input  logic                    hz100,
  input  logic                    reset,
  input  logic                    key_valid,
  input  logic [4:0]              key_code,
  output logic                    mem_req,
  output logic [DATA_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  input  logic                    mem_ack,
  input  logic                    result_valid,
  input  logic [DATA_W-1:0]       result_data,
  output logic [3:0]              op_code,
  output logic [4*DIGITS-1:0]     op1_bcd,
  output logic [4*DIGITS-1:0]     op2_bcd,
  output logic [4*RES_DIGITS-1:0] res_bcd,
  output logic                    res_neg,
  output logic                    res_ovf,
  output logic                    busy
);
  localparam int OW = 4*DIGITS;
  localparam int RW = 4*RES_DIGITS;
  localparam int CW = $clog2(DATA_W+1);
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction
  localparam logic [63:0] LIM = pow10(RES_DIGITS);
  // one double-dabble step: add-3 correction on every digit, then shift in the next bit
  function automatic logic [RW-1:0] dd(input logic [RW-1:0] b, input logic in);
    logic [RW-1:0] t;
    for (int i = 0; i < RES_DIGITS; i++) t[4*i+:4] = (b[4*i+:4] >= 4'd5) ? b[4*i+:4] + 4'd3 : b[4*i+:4];
    return {t[RW-2:0], in};
  endfunction
  typedef enum logic [2:0] {ENTER1, ENTER2, WRITE, WAIT, CONV, SHOW} state_t;
  state_t             state;
  logic [DATA_W-1:0]  bin1, bin2, res_raw, mag;
  logic [3:0]         cnt1, cnt2;
  logic [1:0]         xfer;
  logic               clr_pend, ovf_r;
  logic [RW-1:0]      acc;
  logic [CW-1:0]      k;
  logic               digit, opk, clr, eq, hold, do_clr;
  logic [3:0]         d, op_val;
  logic [DATA_W-1:0]  mag_in;
  assign d      = key_code[3:0];
  assign digit  = key_valid && key_code <= 5'd9;
  assign opk    = key_valid && key_code[4:2] == 3'b100;
  assign clr    = key_valid && key_code == 5'd12;
  assign eq     = key_valid && key_code == 5'd14;
  assign op_val = 4'b0001 << key_code[1:0];
  assign mag_in = result_data[DATA_W-1] ? -result_data : result_data;
  // a clear arriving mid-transfer waits for that transfer's ack
  assign hold   = mem_req && !mem_ack;
  assign do_clr = (clr || clr_pend) && !hold;
  assign busy   = state inside {WRITE, WAIT, CONV};
  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) begin
      state <= ENTER1;
      bin1 <= '0; bin2 <= '0; cnt1 <= '0; cnt2 <= '0;
      op1_bcd <= '0; op2_bcd <= '0; op_code <= '0;
      res_bcd <= '0; res_neg <= 1'b0; res_ovf <= 1'b0;
      mem_req <= 1'b0; mem_addr <= '0; mem_wdata <= '0;
      xfer <= '0; clr_pend <= 1'b0; ovf_r <= 1'b0;
      res_raw <= '0; mag <= '0; acc <= '0; k <= '0;
    end else if (do_clr) begin
      state <= ENTER1;
      bin1 <= '0; bin2 <= '0; cnt1 <= '0; cnt2 <= '0;
      op1_bcd <= '0; op2_bcd <= '0; op_code <= '0;
      res_bcd <= '0; res_neg <= 1'b0; res_ovf <= 1'b0;
      mem_req <= 1'b0; clr_pend <= 1'b0;
    end else begin
      if (clr) clr_pend <= 1'b1;
      case (state)
        ENTER1:
          if (digit && cnt1 < 4'(DIGITS)) begin
            bin1 <= bin1 * DATA_W'(10) + DATA_W'(d);
            op1_bcd <= (op1_bcd << 4) | OW'(d);
            cnt1 <= cnt1 + 4'd1;
          end else if (opk) begin
            op_code <= op_val;
            bin2 <= '0; op2_bcd <= '0; cnt2 <= '0;
            state <= ENTER2;
          end
        ENTER2:
          if (digit && cnt2 < 4'(DIGITS)) begin
            bin2 <= bin2 * DATA_W'(10) + DATA_W'(d);
            op2_bcd <= (op2_bcd << 4) | OW'(d);
            cnt2 <= cnt2 + 4'd1;
          end else if (opk && cnt2 == 4'd0) begin
            op_code <= op_val;
          end else if (eq) begin
            xfer <= '0;
            state <= WRITE;
          end
        WRITE:
          if (!mem_req) begin
            mem_req <= 1'b1;
            mem_addr <= xfer == 2'd0 ? DATA_W'(OP1_ADDR) : xfer == 2'd1 ? DATA_W'(OPC_ADDR) : DATA_W'(OP2_ADDR);
            mem_wdata <= xfer == 2'd0 ? bin1 : xfer == 2'd1 ? DATA_W'(op_code) : bin2;
          end else if (mem_ack) begin
            mem_req <= 1'b0;
            xfer <= xfer + 2'd1;
            if (xfer == 2'd2) state <= WAIT;
          end
        WAIT:
          if (result_valid) begin
            res_raw <= result_data;
            mag <= mag_in;
            ovf_r <= 64'(mag_in) >= LIM;
            acc <= '0;
            k <= '0;
            state <= CONV;
          end
        CONV:
          if (k == CW'(DATA_W)) begin
            res_bcd <= acc;
            res_neg <= res_raw[DATA_W-1];
            res_ovf <= ovf_r;
            state <= SHOW;
          end else begin
            acc <= dd(acc, mag[DATA_W-1]);
            mag <= mag << 1;
            k <= k + CW'(1);
          end
        SHOW:
          if (digit) begin
            bin1 <= DATA_W'(d); op1_bcd <= OW'(d); cnt1 <= 4'd1;
            state <= ENTER1;
          end else if (opk) begin
            bin1 <= res_raw; op1_bcd <= OW'(res_bcd); cnt1 <= 4'(DIGITS);
            op_code <= op_val;
            bin2 <= '0; op2_bcd <= '0; cnt2 <= '0;
            state <= ENTER2;
          end
        default: state <= ENTER1;
      endcase
    end
  end
endmodule

// File: tb/tb_calc_entry_ctrl.sv
// tb_calc_entry_ctrl: directed and randomized key sequences checked against a key-level calculator model.
module tb_calc_entry_ctrl;
  localparam int DIGITS = 2, RES_DIGITS = 4, DATA_W = 32;
  localparam int P1 = 10**DIGITS, PR = 10**RES_DIGITS;
  logic hz100 = 0, reset = 0, key_valid = 0, mem_ack = 0, result_valid = 0;
  logic [4:0] key_code = 0;
  logic [31:0] result_data = 0;
  logic mem_req, res_neg, res_ovf, busy;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0] op_code;
  logic [7:0] op1_bcd, op2_bcd;
  logic [15:0] res_bcd;
  int errors = 0, checks = 0;

  calc_entry_ctrl #(.DIGITS(DIGITS), .RES_DIGITS(RES_DIGITS), .DATA_W(DATA_W)) dut (
    .hz100(hz100), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .result_valid(result_valid), .result_data(result_data), .op_code(op_code),
    .op1_bcd(op1_bcd), .op2_bcd(op2_bcd), .res_bcd(res_bcd), .res_neg(res_neg),
    .res_ovf(res_ovf), .busy(busy));

  always #5 hz100 = ~hz100;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // calculator model, tracked per key press
  logic [31:0] v1 = 0, v2 = 0, mres_raw = 0;
  int b1 = 0, b2 = 0, c1 = 0, c2 = 0, ms = 0;
  logic [3:0] mop = 0;
  longint eres_val = 0;
  logic eneg = 0, eovf = 0;
  logic [63:0] exp_q[$], got_q[$];

  function automatic logic [63:0] to_bcd(input longint v, input int n);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < n; i++) begin
      r[4*i+:4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [3:0] opc(input int k);
    case (k)
      16: return 4'b0001;
      17: return 4'b0010;
      18: return 4'b0100;
      19: return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  // memory side: ack after ack_dly cycles, log writes, check stability and inter-transfer gap
  int ack_dly = 1, wcnt = 0, cyc = 0, last_ack = 0, nseq = 0;
  logic prev_req = 0, prev_ack = 0;
  logic [63:0] prev_aw = 0;
  always @(negedge hz100) begin
    cyc++;
    mem_ack = 0;
    if (mem_req) begin
      if (prev_req && !prev_ack) chk("stable", {mem_addr, mem_wdata}, prev_aw);
      if (!prev_req && nseq > 0) chk("gap", 64'(cyc - last_ack), 2);
      if (wcnt >= ack_dly) begin
        mem_ack = 1;
        got_q.push_back({mem_addr, mem_wdata});
        last_ack = cyc;
        nseq++;
        wcnt = 0;
      end else wcnt++;
    end else wcnt = 0;
    prev_req = mem_req;
    prev_ack = mem_ack;
    prev_aw = {mem_addr, mem_wdata};
  end

  task automatic model_key(input int k);
    bit dig, op;
    dig = k <= 9;
    op = k >= 16 && k <= 19;
    if (k == 12) begin
      v1 = 0; v2 = 0; b1 = 0; b2 = 0; c1 = 0; c2 = 0; mop = 0;
      eres_val = 0; eneg = 0; eovf = 0; ms = 0;
    end else case (ms)
      0: if (dig && c1 < DIGITS) begin
           v1 = v1 * 32'd10 + 32'(k); b1 = (b1 * 10 + k) % P1; c1++;
         end else if (op) begin
           mop = opc(k); v2 = 0; b2 = 0; c2 = 0; ms = 1;
         end
      1: if (dig && c2 < DIGITS) begin
           v2 = v2 * 32'd10 + 32'(k); b2 = (b2 * 10 + k) % P1; c2++;
         end else if (op && c2 == 0) mop = opc(k);
         else if (k == 14) begin
           exp_q.push_back({32'd20000, v1});
           exp_q.push_back({32'd20200, 28'd0, mop});
           exp_q.push_back({32'd20400, v2});
           nseq = 0;
           ms = 2;
         end
      3: if (dig) begin
           v1 = 32'(k); b1 = k; c1 = 1; ms = 0;
         end else if (op) begin
           v1 = mres_raw; b1 = int'(eres_val % P1); c1 = DIGITS;
           mop = opc(k); v2 = 0; b2 = 0; c2 = 0; ms = 1;
         end
      default: ;
    endcase
  endtask

  task automatic press(input int k);
    @(negedge hz100);
    key_valid = 1;
    key_code = 5'(k);
    model_key(k);
    @(negedge hz100);
    key_valid = 0;
  endtask

  task automatic show_chk(input string tag);
    chk({tag, "_op1"}, op1_bcd, to_bcd(b1, DIGITS));
    chk({tag, "_op2"}, op2_bcd, to_bcd(b2, DIGITS));
    chk({tag, "_opc"}, op_code, mop);
  endtask

  task automatic check_writes(input int n);
    int t;
    t = 0;
    while (got_q.size() < n && t < 400) begin
      @(negedge hz100);
      t++;
    end
    chk("write_count", 64'(got_q.size() >= n), 1);
    for (int i = 0; i < n; i++)
      if (got_q.size() > 0 && exp_q.size() > 0) chk("write", got_q.pop_front(), exp_q.pop_front());
  endtask

  task automatic give_result(input logic [31:0] r);
    logic [31:0] m;
    longint mg;
    repeat (2) @(negedge hz100);
    result_data = r;
    result_valid = 1;
    @(negedge hz100);
    result_valid = 0;
    result_data = $urandom;
    repeat (DATA_W) @(negedge hz100);
    chk("conv_busy", busy, 1);
    chk("res_hold", res_bcd, to_bcd(eres_val, RES_DIGITS));
    @(negedge hz100);
    m = r[31] ? -r : r;
    mg = {32'b0, m};
    mres_raw = r; eneg = r[31]; eovf = mg >= PR; eres_val = mg % PR; ms = 3;
    chk("res_bcd", res_bcd, to_bcd(eres_val, RES_DIGITS));
    chk("res_neg", res_neg, eneg);
    chk("res_ovf", res_ovf, eovf);
    chk("show_busy", busy, 0);
  endtask

  initial begin
    int t;
    logic [31:0] r;
    repeat (3) @(negedge hz100);
    reset = 1;
    chk("rst_req", mem_req, 0); chk("rst_addr", mem_addr, 0); chk("rst_wdata", mem_wdata, 0);
    chk("rst_opc", op_code, 0); chk("rst_op1", op1_bcd, 0); chk("rst_op2", op2_bcd, 0);
    chk("rst_res", res_bcd, 0); chk("rst_neg", res_neg, 0); chk("rst_ovf", res_ovf, 0); chk("rst_busy", busy, 0);
    ack_dly = 1;
    press(14); press(4); press(2);
    chk("op1_42", op1_bcd, 8'h42);
    press(19); press(7);
    show_chk("dir1");
    press(14);
    check_writes(3);
    chk("busy_wait", busy, 1);
    give_result(32'd49);
    chk("res_49", res_bcd, 16'h0049);
    @(negedge hz100);
    result_data = 777;
    result_valid = 1;
    @(negedge hz100);
    result_valid = 0;
    repeat (40) @(negedge hz100);
    chk("rv_ignored", res_bcd, 16'h0049);
    chk("rv_ign_busy", busy, 0);
    press(17); press(2);
    show_chk("chain");
    chk("chain_op1", op1_bcd, 8'h49);
    press(14);
    check_writes(3);
    give_result(-32'sd5);
    chk("res_m5", res_bcd, 16'h0005);
    chk("neg_m5", res_neg, 1);
    press(1); press(2); press(3);
    chk("op1_12", op1_bcd, 8'h12);
    press(18); press(9); press(14);
    check_writes(3);
    give_result(32'd123456);
    chk("res_3456", res_bcd, 16'h3456);
    chk("ovf_3456", res_ovf, 1);
    for (int it = 0; it < 12; it++) begin
      int n1, n2;
      ack_dly = $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) press(14);
      n1 = $urandom_range(0, 3);
      for (int j = 0; j < n1; j++) press($urandom_range(0, 9));
      if ($urandom_range(0, 4) == 0) press(13);
      press(16 + $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) press(16 + $urandom_range(0, 3));
      n2 = $urandom_range(0, 3);
      for (int j = 0; j < n2; j++) press($urandom_range(0, 9));
      if (n2 > 0 && $urandom_range(0, 1) == 1) press(16 + $urandom_range(0, 3));
      show_chk("rand");
      press(14);
      check_writes(3);
      case ($urandom_range(0, 2))
        0: r = 32'($urandom_range(0, 9999));
        1: r = -32'($urandom_range(1, 9999));
        default: r = $urandom;
      endcase
      give_result(r);
    end
    ack_dly = 5;
    press(3); press(18); press(4); press(14);
    check_writes(1);
    t = 0;
    while (!mem_req && t < 50) begin
      @(negedge hz100);
      t++;
    end
    chk("opc_req", mem_req, 1);
    press(12);
    chk("req_held", mem_req, 1);
    void'(exp_q.pop_back());
    check_writes(1);
    repeat (15) @(negedge hz100);
    chk("no_op2", 64'(got_q.size()), 0);
    chk("clr_req", mem_req, 0);
    chk("clr_busy", busy, 0);
    chk("clr_res", res_bcd, 0);
    chk("clr_ovf", res_ovf, 0);
    show_chk("clr");
    press(5);
    chk("clr_enter1", op1_bcd, 8'h05);
    ack_dly = 10;
    press(19); press(6); press(14);
    t = 0;
    while (!mem_req && t < 50) begin
      @(negedge hz100);
      t++;
    end
    chk("pre_rst_req", mem_req, 1);
    #2 reset = 0;
    #1;
    chk("arst_req", mem_req, 0); chk("arst_addr", mem_addr, 0); chk("arst_wdata", mem_wdata, 0);
    chk("arst_opc", op_code, 0); chk("arst_op1", op1_bcd, 0); chk("arst_op2", op2_bcd, 0);
    chk("arst_busy", busy, 0);
    @(negedge hz100);
    reset = 1;
    got_q.delete();
    exp_q.delete();
    model_key(12);
    press(8);
    chk("post_rst", op1_bcd, 8'h08);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
